// File: rtl/cache_pkg.sv
// Shared field widths, FSM state encoding and address-slice helpers for the
// direct-mapped 32-line x 4-word cache subsystem.
package cache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 2;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE_MEM,
    RESP
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_word(input logic [TAG_W-1:0]    tag,
                                                  input logic [INDEX_W-1:0]  index,
                                                  input logic [OFFSET_W-1:0] word);
    return {tag, index, word};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Increments the cycle after inc is seen; no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Cache control FSM: hit/miss resolution, whole-line refill on load miss, write-through stores.
// Load hit completes 2 cycles after the request; mem_ready low stretches REFILL/WRITE_MEM.
module cache_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_update,
  output logic              cache_hit,
  input  logic [TAG_W:0]    tag_valid,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   q_addr;
  logic                q_we;
  logic [DATA_W-1:0]   q_wdata;
  logic [OFFSET_W-1:0] k, k_nxt;
  logic                lookup_hit;
  logic                hit_inc, miss_inc;
  logic [ADDR_W-1:0]   refill_addr;

  assign lookup_hit  = tag_valid[TAG_W] && (tag_valid[TAG_W-1:0] == addr_tag(q_addr));
  assign refill_addr = line_word(addr_tag(q_addr), addr_index(q_addr), k);
  assign mem_wdata   = q_wdata;
  assign cpu_rdata   = cache_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      q_addr  <= '0;
      q_we    <= 1'b0;
      q_wdata <= '0;
      k       <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == IDLE && cpu_req) begin
        q_addr  <= cpu_addr;
        q_we    <= cpu_we;
        q_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    cpu_done     = 1'b0;
    cache_addr   = q_addr;
    cache_wdata  = q_wdata;
    cache_update = 1'b0;
    cache_hit    = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = q_addr;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        hit_inc  = lookup_hit;
        miss_inc = !lookup_hit;
        if (q_we) begin
          // Write-through: only a hitting line is updated, a miss goes straight to memory.
          cache_update = lookup_hit;
          state_nxt    = WRITE_MEM;
        end else if (lookup_hit) begin
          cache_hit = 1'b1;
          state_nxt = RESP;
        end else begin
          k_nxt     = '0;
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_rd      = 1'b1;
        mem_addr    = refill_addr;
        cache_addr  = refill_addr;
        cache_wdata = mem_rdata;
        if (mem_ready) begin
          cache_update = 1'b1;
          k_nxt        = k + OFFSET_W'(1);
          if (k == '1) state_nxt = LOOKUP;
        end
      end
      WRITE_MEM: begin
        mem_wr = 1'b1;
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        cpu_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule

// File: doc/cache_controller.md
# cache_controller

Control FSM for the direct-mapped, 32-line × 4-word cache data/tag array of the RISC-V cache subsystem. It sits between the CPU load/store port, the cache array (`update_cache`/`hit` write/read strobes, `tag_valid` lookup) and main memory. It resolves hits and misses, refills whole lines on read miss, and writes through to memory on stores, with no write-allocate. It also keeps saturating hit/miss counters.

## Interface
- `CNT_W`, default 16: width of the hit/miss counters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: request; held stable until `cpu_done`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 10: word address; tag [9:7], index [6:2], offset [1:0].
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data, valid while `cpu_done`.
- `cpu_done` out 1: one-cycle completion pulse.
- `cache_addr` out 10: array address.
- `cache_wdata` out 32: array write data.
- `cache_update` out 1: array write strobe (used with `cache_hit`=0).
- `cache_hit` out 1: array read strobe (used with `cache_update`=0).
- `tag_valid` in 4: {valid, tag[2:0]} of the indexed line, combinational from the array.
- `cache_rdata` in 32: array registered read data.
- `mem_rd`, `mem_wr` out 1: memory read/write request.
- `mem_addr` out 10; `mem_wdata` out 32; `mem_rdata` in 32.
- `mem_ready` in 1: completes the current memory access in the same cycle.
- `hit_count`, `miss_count` out `CNT_W`: saturating event counters.

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE_MEM, RESP.
- IDLE: when `cpu_req`=1, latch addr/we/wdata and go to LOOKUP. Requests are not sampled in any other state.
- LOOKUP: hit = `tag_valid[3]` && (`tag_valid[2:0]` == latched tag), with `cache_addr` = latched addr.
  - Load hit: `cache_hit`=1 for one cycle, `hit_count`++, go to RESP.
  - Load miss: `miss_count`++, clear word counter k, go to REFILL.
  - Store hit: `cache_update`=1 with `cache_wdata` = store data (write-through update), `hit_count`++, go to WRITE_MEM.
  - Store miss: `miss_count`++, go to WRITE_MEM. The array is not touched.
- REFILL: `mem_rd`=1, `mem_addr` = {tag, index, k}.
  - In each cycle with `mem_ready`=1: `cache_update`=1, `cache_addr` = {tag, index, k}, `cache_wdata` = `mem_rdata`, then k++.
  - After k=3 completes, deassert `mem_rd` and return to LOOKUP. The re-lookup now hits and counts as a hit.
  - `mem_rd` stays high across words; the address advances the cycle after each ready.
- WRITE_MEM: `mem_wr`=1, `mem_addr` = latched addr, `mem_wdata` = store data. Hold until `mem_ready`, then go to RESP.
- RESP: `cpu_done`=1 for one cycle. For loads, `cpu_rdata` = `cache_rdata`. Return to IDLE.
- Counters saturate at all-ones and do not wrap.
- `cpu_rdata` is don't-care for stores; drive it with `cache_rdata`.
- `cache_update` and `cache_hit` are never both 1.
- `mem_rd` and `mem_wr` are never both 1.

## Timing
- Reset values:
  - state = IDLE; `cpu_done`, `mem_rd`, `mem_wr`, `cache_update`, `cache_hit` = 0.
  - counters = 0; latched addr/data = 0, so `cache_addr`/`mem_addr`/`cache_wdata`/`mem_wdata` = 0.
- Load hit: request sampled at edge E. LOOKUP occupies E..E+1, and the array registers data at E+1. `cpu_done` is high E+1..E+2, so done is sampled at E+2.
- Load miss with zero-wait memory (`mem_ready` tied 1):
  - LOOKUP 1 cycle, REFILL 4 cycles, LOOKUP 1 cycle, RESP 1 cycle.
  - `cpu_done` is sampled at E+7.
  - Each memory wait cycle adds 1 cycle.
- Store, zero-wait memory: LOOKUP, WRITE_MEM, RESP; `cpu_done` is sampled at E+3.
- `mem_ready` while neither `mem_rd` nor `mem_wr` is asserted is ignored.
- Reset mid-REFILL or mid-WRITE_MEM: immediate return to IDLE with all strobes low. The array shares `rst`, so any partially filled line is invalidated.
- `cpu_req` deasserted early (protocol violation): the transaction still completes.

## Structure
- Shared package `cache_pkg`:
  - field widths TAG_W=3, INDEX_W=5, OFFSET_W=2, ADDR_W=10, DATA_W=32;
  - state enum;
  - field-slice helpers.
- One sub-module `sat_counter` (CNT_W, inc input), instantiated twice for the hit and miss counters.

## Test plan
- Reset, then load 0x0A5 (tag 1, index 9, offset 1), memory returns 0x1000+k for word k, zero wait:
  - `mem_rd` is issued for 0x0A4..0x0A7;
  - `cpu_rdata` = 0x1001, done at E+7;
  - `miss_count`=1, `hit_count`=1.
- Load 0x0A6 immediately after: no `mem_rd`; `cpu_rdata` = 0x1002 at E+2; `hit_count`=2.
- Store 0xDEADBEEF to 0x0A5: array write in LOOKUP; `mem_wr` with addr 0x0A5; then load 0x0A5 returns 0xDEADBEEF with no refill.
- Store to 0x325 (same index 9, tag 6): memory write only; a following load of 0x0A5 still hits; `miss_count` +1.
- Load with 2 wait cycles per word: `mem_addr` is held stable while `mem_ready`=0, and done arrives 8 cycles later than zero-wait.
- Assert `rst` during the third refill word:
  - all strobes go low immediately;
  - a load of the same address after reset misses and refills 4 words;
  - the counters restart from 0.
